// File: rtl/chacha_pkg.sv
// Shared ChaCha definitions: sigma constants, half-round index tables,
// controller state encoding and the 16-word state type.
package chacha_pkg;

   localparam int unsigned WORD_W  = 32;
   localparam int unsigned NWORDS  = 16;
   localparam int unsigned NQR     = 4;
   localparam int unsigned KEY_W   = 256;
   localparam int unsigned NONCE_W = 96;
   localparam int unsigned CTR_W   = 32;
   localparam int unsigned BLOCK_W = NWORDS * WORD_W;

   localparam logic [WORD_W-1:0] SIGMA [4] = '{
      32'h61707865, 32'h3320646e, 32'h79622d32, 32'h6b206574
   };

   // Word indices (a, b, c, d) of each quarter round, per half-round flavour
   localparam logic [3:0] COL_IDX [NQR][4] = '{
      '{4'd0, 4'd4, 4'd8,  4'd12},
      '{4'd1, 4'd5, 4'd9,  4'd13},
      '{4'd2, 4'd6, 4'd10, 4'd14},
      '{4'd3, 4'd7, 4'd11, 4'd15}
   };

   localparam logic [3:0] DIAG_IDX [NQR][4] = '{
      '{4'd0, 4'd5, 4'd10, 4'd15},
      '{4'd1, 4'd6, 4'd11, 4'd12},
      '{4'd2, 4'd7, 4'd8,  4'd13},
      '{4'd3, 4'd4, 4'd9,  4'd14}
   };

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_ROUND = 2'd1;
   localparam logic [1:0] ST_FINAL = 2'd2;
   localparam logic [1:0] ST_DONE  = 2'd3;

   // Word k occupies bits [32k+31:32k] when viewed as a flat vector
   typedef logic [NWORDS-1:0][WORD_W-1:0] state_t;

   function automatic logic [WORD_W-1:0] rotl(input logic [WORD_W-1:0] x,
                                              input int unsigned     s);
      return (x << s) | (x >> (WORD_W - s));
   endfunction

endpackage

// File: rtl/chacha_quarterround.sv
// Single-cycle combinational ChaCha quarter round on four 32-bit words.
module chacha_quarterround
   import chacha_pkg::*;
(
   input  logic [WORD_W-1:0] a_i,
   input  logic [WORD_W-1:0] b_i,
   input  logic [WORD_W-1:0] c_i,
   input  logic [WORD_W-1:0] d_i,
   output logic [WORD_W-1:0] a_o,
   output logic [WORD_W-1:0] b_o,
   output logic [WORD_W-1:0] c_o,
   output logic [WORD_W-1:0] d_o
);

   logic [WORD_W-1:0] a1, b1, c1, d1;
   logic [WORD_W-1:0] a2, b2, c2, d2;

   always_comb begin
      a1 = a_i + b_i;
      d1 = rotl(d_i ^ a1, 16);
      c1 = c_i + d1;
      b1 = rotl(b_i ^ c1, 12);
      a2 = a1 + b1;
      d2 = rotl(d1 ^ a2, 8);
      c2 = c1 + d2;
      b2 = rotl(b1 ^ c2, 7);
   end

   assign a_o = a2;
   assign b_o = b2;
   assign c_o = c2;
   assign d_o = d2;

endmodule

// File: rtl/chacha_block_ctrl.sv
// Iterative ChaCha block function: load, ROUNDS half-rounds through four
// quarter-round units, feed-forward add, then hold the block until taken.
module chacha_block_ctrl
   import chacha_pkg::*;
#(
   parameter int unsigned ROUNDS = 20
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                in_valid,
   output logic                in_ready,
   input  logic [KEY_W-1:0]    in_key,
   input  logic [NONCE_W-1:0]  in_nonce,
   input  logic [CTR_W-1:0]    in_counter,
   output logic                out_valid,
   input  logic                out_ready,
   output logic [BLOCK_W-1:0]  out_block,
   output logic                busy
);

   localparam int unsigned CNT_W = $clog2(ROUNDS);

   logic [1:0]       state_q, state_d;
   state_t           work_q, work_d;
   state_t           init_q, init_d;
   logic [CNT_W-1:0] round_cnt_q, round_cnt_d;
   state_t           out_block_q, out_block_d;
   logic             out_valid_q, out_valid_d;
   logic             in_ready_q, in_ready_d;
   logic             busy_q, busy_d;

   state_t            load_state;
   state_t            half_round;
   state_t            ff_sum;
   logic [3:0]        qr_idx [NQR][4];
   logic [WORD_W-1:0] qr_in  [NQR][4];
   logic [WORD_W-1:0] qr_out [NQR][4];

   // Initial state image assembled from the request buses
   always_comb begin
      for (int i = 0; i < 4; i++) load_state[i] = SIGMA[i];
      for (int i = 0; i < 8; i++) load_state[4 + i] = in_key[WORD_W*i +: WORD_W];
      load_state[12] = in_counter;
      for (int j = 0; j < 3; j++) load_state[13 + j] = in_nonce[WORD_W*j +: WORD_W];
   end

   // Round parity selects column or diagonal operand routing
   always_comb begin
      for (int g = 0; g < NQR; g++) begin
         for (int j = 0; j < 4; j++) begin
            qr_idx[g][j] = round_cnt_q[0] ? DIAG_IDX[g][j] : COL_IDX[g][j];
            qr_in[g][j]  = work_q[qr_idx[g][j]];
         end
      end
   end

   for (genvar g = 0; g < NQR; g++) begin : g_qr
      chacha_quarterround u_qr (
         .a_i (qr_in[g][0]),
         .b_i (qr_in[g][1]),
         .c_i (qr_in[g][2]),
         .d_i (qr_in[g][3]),
         .a_o (qr_out[g][0]),
         .b_o (qr_out[g][1]),
         .c_o (qr_out[g][2]),
         .d_o (qr_out[g][3])
      );
   end

   always_comb begin
      half_round = work_q;
      for (int g = 0; g < NQR; g++) begin
         for (int j = 0; j < 4; j++) half_round[qr_idx[g][j]] = qr_out[g][j];
      end
   end

   always_comb begin
      for (int k = 0; k < NWORDS; k++) ff_sum[k] = work_q[k] + init_q[k];
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= ST_IDLE;
         work_q      <= '0;
         init_q      <= '0;
         round_cnt_q <= '0;
         out_block_q <= '0;
         out_valid_q <= 1'b0;
         in_ready_q  <= 1'b1;
         busy_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         work_q      <= work_d;
         init_q      <= init_d;
         round_cnt_q <= round_cnt_d;
         out_block_q <= out_block_d;
         out_valid_q <= out_valid_d;
         in_ready_q  <= in_ready_d;
         busy_q      <= busy_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      work_d      = work_q;
      init_d      = init_q;
      round_cnt_d = round_cnt_q;
      out_block_d = out_block_q;
      out_valid_d = out_valid_q;

      case (state_q)
         ST_IDLE: begin
            if (in_valid && in_ready_q) begin
               work_d      = load_state;
               init_d      = load_state;
               round_cnt_d = '0;
               state_d     = ST_ROUND;
            end
         end
         ST_ROUND: begin
            work_d      = half_round;
            round_cnt_d = round_cnt_q + CNT_W'(1);
            if (round_cnt_q == CNT_W'(ROUNDS - 1)) state_d = ST_FINAL;
         end
         ST_FINAL: begin
            out_block_d = ff_sum;
            out_valid_d = 1'b1;
            state_d     = ST_DONE;
         end
         ST_DONE: begin
            // A request arriving with the handshake waits for IDLE
            if (out_ready) begin
               out_valid_d = 1'b0;
               state_d     = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase

      in_ready_d = (state_d == ST_IDLE);
      busy_d     = (state_d != ST_IDLE);
   end

   assign in_ready  = in_ready_q;
   assign busy      = busy_q;
   assign out_valid = out_valid_q;
   assign out_block = out_block_q;

endmodule

// File: tb/tb_chacha_block_ctrl.sv
// Scoreboard bench: ChaCha20 instance (directed + random) and ChaCha8
// instance (random), both checked against a plain double-round ChaCha model.
module tb_chacha_block_ctrl;

   localparam int unsigned R_A = 20;
   localparam int unsigned R_B = 8;

   logic         clk = 1'b0;
   logic         rst_n     [2];
   logic         in_valid  [2];
   logic         in_ready  [2];
   logic [255:0] key       [2];
   logic [95:0]  nonce     [2];
   logic [31:0]  ctr       [2];
   logic         out_valid [2];
   logic         out_ready [2];
   logic [511:0] out_block [2];
   logic         busy      [2];

   int unsigned checks = 0;
   int unsigned errors = 0;
   int unsigned cyc    = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   chacha_block_ctrl #(.ROUNDS(R_A)) dut_a (
      .clk        (clk),
      .rst_n      (rst_n[0]),
      .in_valid   (in_valid[0]),
      .in_ready   (in_ready[0]),
      .in_key     (key[0]),
      .in_nonce   (nonce[0]),
      .in_counter (ctr[0]),
      .out_valid  (out_valid[0]),
      .out_ready  (out_ready[0]),
      .out_block  (out_block[0]),
      .busy       (busy[0])
   );

   chacha_block_ctrl #(.ROUNDS(R_B)) dut_b (
      .clk        (clk),
      .rst_n      (rst_n[1]),
      .in_valid   (in_valid[1]),
      .in_ready   (in_ready[1]),
      .in_key     (key[1]),
      .in_nonce   (nonce[1]),
      .in_counter (ctr[1]),
      .out_valid  (out_valid[1]),
      .out_ready  (out_ready[1]),
      .out_block  (out_block[1]),
      .busy       (busy[1])
   );

   function automatic void check(input bit ok, input string name,
                                 input logic [511:0] act, input logic [511:0] req);
      checks++;
      if (!ok) begin
         errors++;
         $display("FAIL %s: actual %0h required %0h", name, act, req);
      end
   endfunction

   function automatic logic [31:0] rotl(input logic [31:0] x, input int unsigned s);
      return (x << s) | (x >> (32 - s));
   endfunction

   function automatic logic [15:0][31:0] qr(input logic [15:0][31:0] v,
                                            input int a, input int b, input int c, input int d);
      v[a] = v[a] + v[b]; v[d] = rotl(v[d] ^ v[a], 16);
      v[c] = v[c] + v[d]; v[b] = rotl(v[b] ^ v[c], 12);
      v[a] = v[a] + v[b]; v[d] = rotl(v[d] ^ v[a], 8);
      v[c] = v[c] + v[d]; v[b] = rotl(v[b] ^ v[c], 7);
      return v;
   endfunction

   function automatic logic [511:0] chacha_ref(input logic [255:0] k, input logic [95:0] n,
                                               input logic [31:0] c, input int unsigned rounds);
      logic [15:0][31:0] s, x;
      s[0] = 32'h61707865; s[1] = 32'h3320646e; s[2] = 32'h79622d32; s[3] = 32'h6b206574;
      for (int i = 0; i < 8; i++) s[4 + i] = k[32*i +: 32];
      s[12] = c;
      for (int i = 0; i < 3; i++) s[13 + i] = n[32*i +: 32];
      x = s;
      for (int r = 0; r < int'(rounds / 2); r++) begin
         x = qr(x, 0, 4, 8, 12); x = qr(x, 1, 5, 9, 13);
         x = qr(x, 2, 6, 10, 14); x = qr(x, 3, 7, 11, 15);
         x = qr(x, 0, 5, 10, 15); x = qr(x, 1, 6, 11, 12);
         x = qr(x, 2, 7, 8, 13);  x = qr(x, 3, 4, 9, 14);
      end
      for (int i = 0; i < 16; i++) x[i] = x[i] + s[i];
      return x;
   endfunction

   function automatic logic [255:0] rand_key();
      logic [255:0] r;
      for (int i = 0; i < 8; i++) r[32*i +: 32] = $urandom;
      return r;
   endfunction

   function automatic logic [95:0] rand_nonce();
      logic [95:0] r;
      for (int i = 0; i < 3; i++) r[32*i +: 32] = $urandom;
      return r;
   endfunction

   // Per-instance scoreboard: expectations pushed at the accept edge,
   // compared whenever the DUT hands over a block
   for (genvar gi = 0; gi < 2; gi++) begin : g_mon
      localparam int unsigned R = (gi == 0) ? R_A : R_B;
      logic [511:0] exp_q [$];
      int unsigned  acc_q [$];
      int unsigned  acc_cnt = 0;
      logic         prev_valid = 1'b0;
      logic         prev_hs = 1'b0;
      logic [511:0] prev_block = '0;

      initial forever begin
         @(posedge clk or negedge rst_n[gi]);
         if (!rst_n[gi]) begin
            exp_q.delete();
            acc_q.delete();
         end else if (in_valid[gi] && in_ready[gi]) begin
            exp_q.push_back(chacha_ref(key[gi], nonce[gi], ctr[gi], R));
            acc_q.push_back(cyc);
            acc_cnt++;
         end
      end

      initial forever begin
         int unsigned  lat;
         logic [511:0] exp;
         @(negedge clk);
         #1;
         if (!rst_n[gi]) begin
            prev_valid = 1'b0;
            prev_hs    = 1'b0;
         end else begin
            if (out_valid[gi] && !prev_valid) begin
               if (acc_q.size() == 0) begin
                  check(1'b0, "valid_without_request", 512'(out_valid[gi]), 512'(0));
               end else begin
                  lat = cyc - acc_q.pop_front();
                  check(lat == R + 2, "latency", 512'(lat), 512'(R + 2));
               end
            end
            if (prev_valid && !prev_hs)
               check(out_valid[gi] && (out_block[gi] == prev_block), "hold_stable",
                     out_block[gi], prev_block);
            if (out_valid[gi])
               check(!in_ready[gi], "in_ready_while_valid", 512'(in_ready[gi]), 512'(0));
            check(busy[gi] == !in_ready[gi], "busy_vs_in_ready", 512'(busy[gi]), 512'(!in_ready[gi]));
            if (out_valid[gi] && out_ready[gi]) begin
               if (exp_q.size() == 0) begin
                  check(1'b0, "block_without_request", out_block[gi], 512'(0));
               end else begin
                  exp = exp_q.pop_front();
                  check(out_block[gi] == exp, "block", out_block[gi], exp);
               end
            end
            prev_valid = out_valid[gi];
            prev_hs    = out_valid[gi] && out_ready[gi];
            prev_block = out_block[gi];
         end
      end
   end

   // Called at a falling edge; returns at the falling edge after the accept edge
   task automatic send(input int i, input logic [255:0] k, input logic [95:0] n,
                       input logic [31:0] c, input bit hold, output int unsigned acc_t);
      bit acc = 1'b0;
      key[i] = k; nonce[i] = n; ctr[i] = c; in_valid[i] = 1'b1;
      for (int t = 0; t < 200 && !acc; t++) begin
         acc = in_ready[i];
         @(posedge clk);
         @(negedge clk);
      end
      acc_t = cyc - 1;
      check(acc, "accept_timeout", 512'(acc), 512'(1));
      if (!hold) in_valid[i] = 1'b0;
   endtask

   task automatic recv(input int i, input bit bp, output logic [511:0] blk);
      bit hs = 1'b0;
      blk = '0;
      for (int t = 0; t < 400 && !hs; t++) begin
         out_ready[i] = bp ? 1'($urandom_range(0, 1)) : 1'b1;
         hs = out_valid[i] && out_ready[i];
         if (hs) blk = out_block[i];
         @(posedge clk);
         @(negedge clk);
      end
      out_ready[i] = 1'b1;
      check(hs, "output_timeout", 512'(hs), 512'(1));
   endtask

   task automatic run_a();
      logic [255:0] k;
      logic [95:0]  n;
      logic [511:0] blk;
      int unsigned  t0, t1, t2, a0;

      check(in_ready[0] == 1'b1, "rst_in_ready", 512'(in_ready[0]), 512'(1));
      check(busy[0] == 1'b0, "rst_busy", 512'(busy[0]), 512'(0));
      check(out_valid[0] == 1'b0, "rst_out_valid", 512'(out_valid[0]), 512'(0));
      check(out_block[0] == '0, "rst_out_block", out_block[0], 512'(0));

      for (int b = 0; b < 32; b++) k[8*b +: 8] = 8'(b);
      n = {32'h00000000, 32'h4a000000, 32'h09000000};
      send(0, k, n, 32'd1, 1'b0, t0);
      recv(0, 1'b0, blk);
      check(blk[31:0] == 32'he4e7f110, "rfc_word0", 512'(blk[31:0]), 512'(32'he4e7f110));
      check(blk[63:32] == 32'h15593bd1, "rfc_word1", 512'(blk[63:32]), 512'(32'h15593bd1));

      send(0, '0, '0, '0, 1'b0, t0);
      recv(0, 1'b0, blk);
      check(blk[31:0] == 32'hade0b876, "zero_word0", 512'(blk[31:0]), 512'(32'hade0b876));
      check(blk[63:32] == 32'h903df1a0, "zero_word1", 512'(blk[63:32]), 512'(32'h903df1a0));

      // Backpressure: block held, stray requests ignored
      out_ready[0] = 1'b0;
      send(0, rand_key(), rand_nonce(), $urandom, 1'b0, t0);
      for (int t = 0; t < 100 && !out_valid[0]; t++) @(negedge clk);
      a0 = g_mon[0].acc_cnt;
      for (int t = 0; t < 10; t++) begin
         in_valid[0] = 1'($urandom_range(0, 1));
         key[0] = rand_key(); nonce[0] = rand_nonce(); ctr[0] = $urandom;
         check(out_valid[0] && !in_ready[0], "bp_window",
               512'({out_valid[0], in_ready[0]}), 512'(2'b10));
         @(posedge clk);
         @(negedge clk);
      end
      in_valid[0] = 1'b0;
      check(g_mon[0].acc_cnt == a0, "bp_no_accept", 512'(g_mon[0].acc_cnt), 512'(a0));
      recv(0, 1'b0, blk);

      // Back-to-back with in_valid held and out_ready tied high
      k = rand_key();
      n = rand_nonce();
      send(0, k, n, 32'd0, 1'b1, t0);
      send(0, k, n, 32'd1, 1'b1, t1);
      send(0, k, n, 32'd2, 1'b0, t2);
      check(t1 - t0 == R_A + 3, "b2b_spacing_1", 512'(t1 - t0), 512'(R_A + 3));
      check(t2 - t1 == R_A + 3, "b2b_spacing_2", 512'(t2 - t1), 512'(R_A + 3));
      recv(0, 1'b0, blk);

      // Abort mid-ROUND
      send(0, rand_key(), rand_nonce(), $urandom, 1'b0, t0);
      repeat (5) @(posedge clk);
      #3 rst_n[0] = 1'b0;
      #1;
      check(out_valid[0] == 1'b0, "abort_out_valid", 512'(out_valid[0]), 512'(0));
      check(busy[0] == 1'b0, "abort_busy", 512'(busy[0]), 512'(0));
      check(out_block[0] == '0, "abort_out_block", out_block[0], 512'(0));
      @(negedge clk);
      rst_n[0] = 1'b1;
      @(negedge clk);
      check(in_ready[0] == 1'b1, "abort_in_ready", 512'(in_ready[0]), 512'(1));
      send(0, rand_key(), rand_nonce(), $urandom, 1'b0, t0);
      recv(0, 1'b0, blk);

      for (int r = 0; r < 30; r++) begin
         send(0, rand_key(), rand_nonce(), $urandom, 1'b0, t0);
         recv(0, 1'b1, blk);
         repeat ($urandom_range(0, 2)) @(negedge clk);
      end
   endtask

   task automatic run_b();
      logic [511:0] blk;
      int unsigned  t0;
      for (int r = 0; r < 1000; r++) begin
         send(1, rand_key(), rand_nonce(), $urandom, 1'b0, t0);
         recv(1, 1'b1, blk);
      end
   endtask

   initial begin
      rst_n = '{1'b0, 1'b0};
      for (int i = 0; i < 2; i++) begin
         in_valid[i]  = 1'b0;
         out_ready[i] = 1'b1;
         key[i]       = '0;
         nonce[i]     = '0;
         ctr[i]       = '0;
      end
      repeat (3) @(negedge clk);
      rst_n = '{1'b1, 1'b1};
      @(negedge clk);
      fork
         run_a();
         run_b();
      join
      repeat (5) @(negedge clk);
      check(g_mon[0].exp_q.size() == 0, "drain_a", 512'(g_mon[0].exp_q.size()), 512'(0));
      check(g_mon[1].exp_q.size() == 0, "drain_b", 512'(g_mon[1].exp_q.size()), 512'(0));
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: actual timeout required completion");
      $fatal(1, "simulation time limit reached");
   end

endmodule
